prach_hb2_pack: RTL and testbench
=================================

// Module: prach_hb2_pack
// PURPOSE
// - Polyphase packer directly upstream of the per-channel HB2 decimator.
// - Accepts a TDM stream of one 16-bit sample per valid beat, tagged with channel 0..NUM_CHANNEL-1.
// - Per channel, pairs consecutive samples (even, odd) and emits them together as dout_dp2/dout_dp1.
// - Emits one paired beat per two input samples, preserving channel tag; sync is passed with fixed latency.
// PARAMETERS
// - NUM_CHANNEL  32  number of TDM channels; legal din_chn range 0..NUM_CHANNEL-1
// - DATA_WIDTH   16  sample width (two's complement)
// - CHN_WIDTH     8  channel tag width
// PORTS
// - clk          in   1           single clock; all logic on posedge
// - rst          in   1           asynchronous, active-high reset
// - din_d        in   DATA_WIDTH  input sample
// - din_dv       in   1           input sample valid
// - din_chn      in   CHN_WIDTH   channel tag of din_d
// - sync_in      in   1           frame sync pulse; realigns phase of all channels
// - dout_dp1     out  DATA_WIDTH  odd (later) sample of the pair
// - dout_dp2     out  DATA_WIDTH  even (earlier) sample of the pair
// - dout_dv      out  1           pair valid
// - dout_chn     out  CHN_WIDTH   channel tag of the pair
// - sync_out     out  1           sync_in delayed by LATENCY
// - err_chn      out  1           sticky: a valid beat carried din_chn >= NUM_CHANNEL
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - all outputs 0; phase[] cleared; pipeline valids cleared.
//   - Even-sample RAM is not reset; phase[] gates its use.
// - Per-channel state phase[c]:
//   - 0 = expecting even sample; 1 = holding even sample in RAM[c].
// - Valid beat with din_chn=c, c < NUM_CHANNEL:
//   - phase[c]=0: write din_d to RAM[c]; set phase[c]=1; no output.
//   - phase[c]=1: read RAM[c] as dp2, take din_d as dp1, clear phase[c], emit pair.
// - LATENCY = 2 cycles from input beat to dout_dv:
//   - stage 1: RAM read and capture of din_d/chn.
//   - stage 2: output register.
// - Read-during-write bypass: if the even write to RAM[c] occurred in the previous cycle and the odd read of c occurs now, dp2 comes from the write-data register, not the RAM. Back-to-back same-channel beats must pair correctly.
// - sync_in = 1:
//   - Clears every phase bit in that cycle.
//   - A valid beat coincident with sync_in is treated as an even sample for its channel (phase becomes 1 for that channel only).
//   - Pairs already in the pipeline still complete.
// - sync_out: sync_in delayed exactly LATENCY cycles, independent of dout_dv.
// - Invalid channel (din_chn >= NUM_CHANNEL) with din_dv:
//   - Beat dropped; no RAM or phase change.
//   - err_chn set; cleared only by rst.
// - din_dv = 0: no state change except sync handling.
// - Data path: no arithmetic; samples pass bit-exact.
// - dout_dp1/dp2/chn hold their last value while dout_dv = 0.
// - Throughput: one input beat per cycle sustained, any channel order. Output rate is at most one pair per two beats of the same channel.
// STRUCTURE
// - prach_pkg holds:
//   - NumChannel = 32, DataWidth = 16, ChnWidth = 8.
//   - typedef logic signed [DataWidth-1:0] sample_t.
//   - typedef logic [ChnWidth-1:0] chn_t.
// - One sub-module: prach_sdp_ram.
//   - Simple dual-port RAM, NUM_CHANNEL x DATA_WIDTH.
//   - Registered read, no reset, write-first not assumed (bypass lives in this block).
// - The block contains phase[] register vector, bypass compare, two pipeline stages and the sync delay.
// TESTING
// - Round-robin ch0..31, samples n*32+c for n=0..3:
//   - Each channel emits pairs (dp2,dp1) = (c, 32+c), then (64+c, 96+c).
//   - dout_dv lags the odd beat by exactly 2 cycles.
// - Single channel 5, back-to-back beats 0x1111, 0x2222 on consecutive cycles:
//   - Bypass path hit.
//   - Output dp2=0x1111, dp1=0x2222, chn=5, two cycles after 0x2222.
// - ch3 gets 0xAAAA; then sync_in with valid ch3 0xBBBB; then ch3 0xCCCC:
//   - Pair is (0xBBBB, 0xCCCC).
//   - 0xAAAA is discarded.
//   - sync_out pulses 2 cycles after sync_in.
// - Valid beat with din_chn=40:
//   - No dout_dv.
//   - err_chn = 1 from the next cycle, stays 1.
//   - Other channels unaffected.
// - rst pulsed mid-stream with ch7 holding an even sample and a pair in flight:
//   - All outputs 0 immediately.
//   - No pair emitted after release.
//   - ch7 restarts at even phase.
// - Random dv gaps and random channel order vs. reference model, 10k beats: exact match of pairs, tags and sync_out.

Source files
------------

// File: rtl/prach_pkg.sv
// Shared constants and types for the PRACH HB2 polyphase packer.
package prach_pkg;
  localparam int unsigned NumChannel = 32;
  localparam int unsigned DataWidth  = 16;
  localparam int unsigned ChnWidth   = 8;
  localparam int unsigned AddrWidth  = $clog2(NumChannel);

  typedef logic signed [DataWidth-1:0] sample_t;
  typedef logic [ChnWidth-1:0]         chn_t;
  typedef logic [AddrWidth-1:0]        addr_t;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  function automatic logic chn_legal(input chn_t c);
    return 32'(c) < NumChannel;
  endfunction
endpackage

// File: rtl/prach_hb2_pack_if.sv
// TDM sample stream in, paired-sample stream out, plus sync and error flag.
interface prach_hb2_pack_if;
  import prach_pkg::*;

  sample_t din_d;
  logic    din_dv;
  chn_t    din_chn;
  logic    sync_in;
  sample_t dout_dp1;
  sample_t dout_dp2;
  logic    dout_dv;
  chn_t    dout_chn;
  logic    sync_out;
  logic    err_chn;

  modport master (
    output din_d, din_dv, din_chn, sync_in,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );

  modport slave (
    input  din_d, din_dv, din_chn, sync_in,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );
endinterface

// File: rtl/prach_sdp_ram.sv
// Simple dual-port RAM holding one even sample per channel; registered read, no reset.
module prach_sdp_ram
  import prach_pkg::*;
(
  input  logic    clk,
  input  logic    we,
  input  addr_t   waddr,
  input  sample_t wdata,
  input  logic    re,
  input  addr_t   raddr,
  output sample_t rdata
);
  sample_t mem_q [NumChannel];
  sample_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/prach_hb2_pack.sv
// Pairs consecutive per-channel samples of a TDM stream into (even, odd) beats
// for the HB2 decimator; two-cycle latency, sync_in realigns all channel phases.
module prach_hb2_pack
  import prach_pkg::*;
(
  input logic              clk,
  input logic              rst,
  prach_hb2_pack_if.slave  bus
);
  phase_e  phase_q [NumChannel];
  phase_e  phase_d [NumChannel];
  logic    wr_en_q, wr_en_d;
  addr_t   wr_addr_q, wr_addr_d;
  sample_t wr_data_q, wr_data_d;
  logic    s1_dv_q, s1_dv_d;
  chn_t    s1_chn_q, s1_chn_d;
  sample_t s1_dp1_q, s1_dp1_d;
  logic    s1_byp_q, s1_byp_d;
  sample_t s1_byp_data_q, s1_byp_data_d;
  logic    dout_dv_q, dout_dv_d;
  chn_t    dout_chn_q, dout_chn_d;
  sample_t dout_dp1_q, dout_dp1_d;
  sample_t dout_dp2_q, dout_dp2_d;
  logic    sync1_q, sync1_d;
  logic    sync_out_q, sync_out_d;
  logic    err_q, err_d;

  addr_t   chn_idx;
  logic    chn_ok;
  logic    beat_ok;
  logic    is_odd;
  sample_t ram_rdata;

  // Even writes land one cycle late from wr_*_q, so an odd read of the same
  // channel in that cycle must take dp2 from wr_data_q instead of the RAM.
  prach_sdp_ram u_ram (
    .clk   (clk),
    .we    (wr_en_q),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .re    (is_odd),
    .raddr (chn_idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    chn_idx = bus.din_chn[AddrWidth-1:0];
    chn_ok  = chn_legal(bus.din_chn);
    beat_ok = bus.din_dv && chn_ok;
    is_odd  = beat_ok && !bus.sync_in && (phase_q[chn_idx] == PH_ODD);

    phase_d = phase_q;
    if (bus.sync_in) begin
      for (int unsigned i = 0; i < NumChannel; i++) phase_d[i] = PH_EVEN;
    end
    if (beat_ok) phase_d[chn_idx] = is_odd ? PH_EVEN : PH_ODD;

    wr_en_d   = beat_ok && !is_odd;
    wr_addr_d = chn_idx;
    wr_data_d = bus.din_d;

    s1_dv_d       = is_odd;
    s1_chn_d      = s1_chn_q;
    s1_dp1_d      = s1_dp1_q;
    s1_byp_d      = s1_byp_q;
    s1_byp_data_d = s1_byp_data_q;
    if (is_odd) begin
      s1_chn_d      = bus.din_chn;
      s1_dp1_d      = bus.din_d;
      s1_byp_d      = wr_en_q && (wr_addr_q == chn_idx);
      s1_byp_data_d = wr_data_q;
    end

    dout_dv_d  = s1_dv_q;
    dout_chn_d = dout_chn_q;
    dout_dp1_d = dout_dp1_q;
    dout_dp2_d = dout_dp2_q;
    if (s1_dv_q) begin
      dout_chn_d = s1_chn_q;
      dout_dp1_d = s1_dp1_q;
      dout_dp2_d = s1_byp_q ? s1_byp_data_q : ram_rdata;
    end

    sync1_d    = bus.sync_in;
    sync_out_d = sync1_q;
    err_d      = err_q | (bus.din_dv && !chn_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumChannel; i++) phase_q[i] <= PH_EVEN;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      s1_dv_q       <= 1'b0;
      s1_chn_q      <= '0;
      s1_dp1_q      <= '0;
      s1_byp_q      <= 1'b0;
      s1_byp_data_q <= '0;
      dout_dv_q     <= 1'b0;
      dout_chn_q    <= '0;
      dout_dp1_q    <= '0;
      dout_dp2_q    <= '0;
      sync1_q       <= 1'b0;
      sync_out_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      s1_dv_q       <= s1_dv_d;
      s1_chn_q      <= s1_chn_d;
      s1_dp1_q      <= s1_dp1_d;
      s1_byp_q      <= s1_byp_d;
      s1_byp_data_q <= s1_byp_data_d;
      dout_dv_q     <= dout_dv_d;
      dout_chn_q    <= dout_chn_d;
      dout_dp1_q    <= dout_dp1_d;
      dout_dp2_q    <= dout_dp2_d;
      sync1_q       <= sync1_d;
      sync_out_q    <= sync_out_d;
      err_q         <= err_d;
    end
  end

  assign bus.dout_dv  = dout_dv_q;
  assign bus.dout_chn = dout_chn_q;
  assign bus.dout_dp1 = dout_dp1_q;
  assign bus.dout_dp2 = dout_dp2_q;
  assign bus.sync_out = sync_out_q;
  assign bus.err_chn  = err_q;
endmodule

// File: tb/tb_prach_hb2_pack.sv
// Bench for prach_hb2_pack: queue-based pairing model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_prach_hb2_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;

  prach_hb2_pack_if bus ();

  prach_hb2_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-channel "holding an even sample" flag and value; pairs and
  // syncs queued with the edge count after which they must be visible.
  typedef struct {
    int          due;
    logic [7:0]  chn;
    logic [15:0] dp2;
    logic [15:0] dp1;
  } pair_t;

  pair_t       pq[$];
  int          sq[$];
  logic        pend [32];
  logic [15:0] held [32];
  logic        err_m;
  logic [15:0] last_dp1, last_dp2;
  logic [7:0]  last_chn;
  int          ecnt = 0;

  task automatic model_clear();
    pq.delete();
    sq.delete();
    for (int c = 0; c < 32; c++) pend[c] = 1'b0;
    err_m    = 1'b0;
    last_dp1 = '0;
    last_dp2 = '0;
    last_chn = '0;
  endtask

  initial model_clear();

  always @(clk) begin
    if (clk) begin
      ecnt++;
      if (rst) begin
        model_clear();
      end else begin
        if (bus.sync_in) begin
          for (int c = 0; c < 32; c++) pend[c] = 1'b0;
          sq.push_back(ecnt + 1);
        end
        if (bus.din_dv) begin
          if (int'(bus.din_chn) >= 32) begin
            err_m = 1'b1;
          end else if (pend[bus.din_chn]) begin
            pq.push_back('{ecnt + 1, bus.din_chn, held[bus.din_chn], unsigned'(bus.din_d)});
            pend[bus.din_chn] = 1'b0;
          end else begin
            held[bus.din_chn] = unsigned'(bus.din_d);
            pend[bus.din_chn] = 1'b1;
          end
        end
      end
    end else begin
      if (rst) begin
        model_clear();
        check("rst_dv",   32'(bus.dout_dv), 32'd0);
        check("rst_dp1",  32'(unsigned'(bus.dout_dp1)), 32'd0);
        check("rst_dp2",  32'(unsigned'(bus.dout_dp2)), 32'd0);
        check("rst_chn",  32'(bus.dout_chn), 32'd0);
        check("rst_sync", 32'(bus.sync_out), 32'd0);
        check("rst_err",  32'(bus.err_chn), 32'd0);
      end else begin
        logic exp_dv, exp_sync;
        exp_dv = (pq.size() > 0) && (pq[0].due == ecnt);
        if (exp_dv) begin
          last_dp1 = pq[0].dp1;
          last_dp2 = pq[0].dp2;
          last_chn = pq[0].chn;
          void'(pq.pop_front());
        end
        exp_sync = (sq.size() > 0) && (sq[0] == ecnt);
        if (exp_sync) void'(sq.pop_front());
        check("dout_dv",  32'(bus.dout_dv), 32'(exp_dv));
        check("dout_dp1", 32'(unsigned'(bus.dout_dp1)), 32'(last_dp1));
        check("dout_dp2", 32'(unsigned'(bus.dout_dp2)), 32'(last_dp2));
        check("dout_chn", 32'(bus.dout_chn), 32'(last_chn));
        check("sync_out", 32'(bus.sync_out), 32'(exp_sync));
        check("err_chn",  32'(bus.err_chn), 32'(err_m));
      end
    end
  end

  task automatic beat(input logic dv, input int chn, input int d, input logic sy);
    bus.din_dv  = dv;
    bus.din_chn = 8'(chn);
    bus.din_d   = 16'(d);
    bus.sync_in = sy;
    @(posedge clk);
    #1;
    bus.din_dv  = 1'b0;
    bus.sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_pair(input string name, input int chn, input int dp2, input int dp1);
    check({name, "_dv"},  32'(bus.dout_dv), 32'd1);
    check({name, "_chn"}, 32'(bus.dout_chn), 32'(chn));
    check({name, "_dp2"}, 32'(unsigned'(bus.dout_dp2)), 32'(dp2));
    check({name, "_dp1"}, 32'(unsigned'(bus.dout_dp1)), 32'(dp1));
  endtask

  initial begin
    bus.din_dv  = 1'b0;
    bus.din_chn = '0;
    bus.din_d   = '0;
    bus.sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Round-robin: sample n*32+c on channel c.
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 32; c++) begin
        beat(1'b1, c, n * 32 + c, 1'b0);
        if (n == 1 && c == 0) check("rr_lat1", 32'(bus.dout_dv), 32'd0);
        if (n == 1 && c == 1) check_pair("rr_first", 0, 0, 32);
      end
    end
    idle(1);
    check_pair("rr_last", 31, 95, 127);
    idle(2);

    // Back-to-back same channel through the bypass.
    beat(1'b1, 5, 16'h1111, 1'b0);
    beat(1'b1, 5, 16'h2222, 1'b0);
    check("byp_lat1", 32'(bus.dout_dv), 32'd0);
    idle(1);
    check_pair("byp", 5, 16'h1111, 16'h2222);
    idle(2);

    // Sync realigns: 0xAAAA discarded, pair is (0xBBBB, 0xCCCC).
    beat(1'b1, 3, 16'hAAAA, 1'b0);
    beat(1'b1, 3, 16'hBBBB, 1'b1);
    check("sync_lat1", 32'(bus.sync_out), 32'd0);
    beat(1'b1, 3, 16'hCCCC, 1'b0);
    check("sync_lat2", 32'(bus.sync_out), 32'd1);
    check("sync_nodv", 32'(bus.dout_dv), 32'd0);
    idle(1);
    check_pair("sync", 3, 16'hBBBB, 16'hCCCC);
    check("sync_off", 32'(bus.sync_out), 32'd0);
    idle(2);

    // Illegal channel: dropped, sticky error, others unaffected.
    check("err_pre", 32'(bus.err_chn), 32'd0);
    beat(1'b1, 9, 16'h0901, 1'b0);
    beat(1'b1, 40, 16'h4040, 1'b0);
    check("err_set", 32'(bus.err_chn), 32'd1);
    beat(1'b1, 9, 16'h0902, 1'b0);
    idle(1);
    check_pair("err_other", 9, 16'h0901, 16'h0902);
    idle(3);
    check("err_sticky", 32'(bus.err_chn), 32'd1);

    // Reset with ch7 holding an even sample and a ch2 pair in flight.
    beat(1'b1, 7, 16'h0777, 1'b0);
    beat(1'b1, 2, 16'h0222, 1'b0);
    beat(1'b1, 2, 16'h0223, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_dv",  32'(bus.dout_dv), 32'd0);
    check("arst_dp2", 32'(unsigned'(bus.dout_dp2)), 32'd0);
    check("arst_chn", 32'(bus.dout_chn), 32'd0);
    check("arst_err", 32'(bus.err_chn), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    beat(1'b1, 7, 16'h7001, 1'b0);
    beat(1'b1, 7, 16'h7002, 1'b0);
    idle(1);
    check_pair("rst_ch7", 7, 16'h7001, 16'h7002);
    idle(2);

    // Random gaps, channel order, occasional sync and illegal tags.
    for (int i = 0; i < 10000; i++) begin
      logic dv, sy;
      int   chn;
      dv = ($urandom_range(0, 99) < 75);
      sy = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 2)       chn = int'($urandom_range(32, 255));
      else if ($urandom_range(0, 1) == 0)  chn = int'($urandom_range(0, 3));
      else                                 chn = int'($urandom_range(0, 31));
      beat(dv, chn, int'($urandom_range(0, 65535)), sy);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
